// File: rtl/neuron_seq_ctrl.sv
// Sequences one shared neuron datapath over NUM_NEURONS outputs: fetch params, load, evaluate, emit.
// Latency: first y_valid 3 cycles after start, 4-cycle stride; backpressure: OUT holds y_* until y_ready.
module neuron_seq_ctrl #(
   parameter int NUM_NEURONS = 8,
   parameter int IDX_W       = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [31:0]      x_in,
   input  logic             cfg_we,
   input  logic [11:0]      cfg_xmin,
   input  logic [11:0]      cfg_xmax,
   output logic [IDX_W-1:0] p_addr,
   output logic             p_rd,
   input  logic [47:0]      p_data,
   output logic [31:0]      n_x,
   output logic [31:0]      n_w,
   output logic [15:0]      n_bias,
   output logic [11:0]      n_xmin,
   output logic [11:0]      n_xmax,
   input  logic [7:0]       n_y,
   output logic             y_valid,
   output logic [7:0]       y_data,
   output logic [IDX_W-1:0] y_idx,
   input  logic             y_ready,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      EVAL  = 3'd3,
      OUT   = 3'd4,
      DONE  = 3'd5
   } state_t;

   typedef struct packed {
      logic [15:0] bias;
      logic [31:0] w;
   } pword_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

   state_t          state;
   logic [IDX_W-1:0] idx;
   pword_t          pword;

   assign pword = pword_t'(p_data);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         idx     <= '0;
         p_addr  <= '0;
         p_rd    <= 1'b0;
         n_x     <= '0;
         n_w     <= '0;
         n_bias  <= '0;
         n_xmin  <= 12'hF80;
         n_xmax  <= 12'h07F;
         y_valid <= 1'b0;
         y_data  <= '0;
         y_idx   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         p_rd <= 1'b0;
         done <= 1'b0;
         // Abort only applies to a layer in flight; in IDLE a coincident start wins.
         if (state != IDLE && abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            y_valid <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (cfg_we) begin
                     n_xmin <= cfg_xmin;
                     n_xmax <= cfg_xmax;
                  end
                  if (start) begin
                     n_x    <= x_in;
                     idx    <= '0;
                     p_addr <= '0;
                     p_rd   <= 1'b1;
                     busy   <= 1'b1;
                     state  <= FETCH;
                  end
               end
               FETCH: state <= LOAD;
               LOAD: begin
                  n_w    <= pword.w;
                  n_bias <= pword.bias;
                  state  <= EVAL;
               end
               EVAL: begin
                  y_data  <= n_y;
                  y_idx   <= idx;
                  y_valid <= 1'b1;
                  state   <= OUT;
               end
               OUT: begin
                  if (y_valid && y_ready) begin
                     y_valid <= 1'b0;
                     if (idx == LAST_IDX) begin
                        state <= DONE;
                     end else begin
                        idx    <= idx + 1'b1;
                        p_addr <= idx + 1'b1;
                        p_rd   <= 1'b1;
                        state  <= FETCH;
                     end
                  end
               end
               DONE: begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Scoreboarded bench for neuron_seq_ctrl: stimulus queues expected outputs, a negedge monitor checks them.
module tb_neuron_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] x_in = '0;
   logic        cfg_we = 1'b0;
   logic [11:0] cfg_xmin = '0;
   logic [11:0] cfg_xmax = '0;
   logic [2:0]  p_addr;
   logic        p_rd;
   logic [47:0] p_data = '0;
   logic [31:0] n_x, n_w;
   logic [15:0] n_bias;
   logic [11:0] n_xmin, n_xmax;
   logic [7:0]  n_y;
   logic        y_valid;
   logic [7:0]  y_data;
   logic [2:0]  y_idx;
   logic        y_ready = 1'b1;
   logic        busy, done;

   neuron_seq_ctrl #(.NUM_NEURONS(8), .IDX_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .x_in(x_in),
      .cfg_we(cfg_we), .cfg_xmin(cfg_xmin), .cfg_xmax(cfg_xmax),
      .p_addr(p_addr), .p_rd(p_rd), .p_data(p_data),
      .n_x(n_x), .n_w(n_w), .n_bias(n_bias), .n_xmin(n_xmin), .n_xmax(n_xmax),
      .n_y(n_y), .y_valid(y_valid), .y_data(y_data), .y_idx(y_idx),
      .y_ready(y_ready), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Parameter memory: word k = {bias 0, W4..W1 all k}; poison when not read.
   always @(posedge clk) begin
      if (p_rd) p_data <= {16'h0000, {4{8'(p_addr)}}};
      else      p_data <= 48'hBAD0_BAD0_BAD0;
   end

   // Pass-through neuron: result is W1.
   assign n_y = n_w[7:0];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [2:0]  idx;
      logic [7:0]  data;
      logic [31:0] w;
      logic [31:0] x;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   t0 = 0;
   int   exp_lat = 0;
   bit   done_exp = 1'b0;
   bit   first_pending = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
      end
   endtask

   task automatic push_layer(input logic [31:0] x);
      for (int k = 0; k < 8; k++) begin
         exp_t e;
         e.idx  = 3'(k);
         e.data = 8'(k);
         e.w    = {4{8'(k)}};
         e.x    = x;
         sb.push_back(e);
      end
   endtask

   task automatic launch(input logic [31:0] x, input int lat, input bit dexp,
                         input logic we, input logic [11:0] xmin, input logic [11:0] xmax);
      @(posedge clk); #1;
      start = 1'b1; x_in = x; cfg_we = we; cfg_xmin = xmin; cfg_xmax = xmax;
      @(posedge clk); #1;
      start = 1'b0; cfg_we = 1'b0;
      t0 = cyc; first_pending = 1'b1; done_exp = dexp; exp_lat = lat;
   endtask

   // Monitor
   bit         hs_q = 1'b0, hold_q = 1'b0;
   logic [7:0] hold_d = '0;
   logic [2:0] hold_i = '0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (hs_q) chk("yvalid_drop", 64'(y_valid), 64'd0);
         if (hold_q) begin
            chk("hold_valid", 64'(y_valid), 64'd1);
            chk("hold_data", 64'(y_data), 64'(hold_d));
            chk("hold_idx", 64'(y_idx), 64'(hold_i));
            chk("hold_no_prd", 64'(p_rd), 64'd0);
         end
         if (y_valid && first_pending) begin
            chk("first_latency", 64'(cyc - t0), 64'd3);
            first_pending = 1'b0;
         end
         if (y_valid && y_ready) begin
            if (sb.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_output actual idx=%0d data=%0h expected none", y_idx, y_data);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("y_idx", 64'(y_idx), 64'(e.idx));
               chk("y_data", 64'(y_data), 64'(e.data));
               chk("n_w", 64'(n_w), 64'(e.w));
               chk("n_x", 64'(n_x), 64'(e.x));
               chk("n_bias", 64'(n_bias), 64'd0);
            end
         end
         if (done) begin
            if (!done_exp) begin
               checks++; failures++;
               $display("FAIL unexpected_done actual=1 expected=0");
            end else begin
               chk("done_latency", 64'(cyc - t0), 64'(exp_lat));
               chk("busy_at_done", 64'(busy), 64'd0);
            end
            done_exp = 1'b0;
         end
         hs_q   = y_valid && y_ready;
         hold_q = y_valid && !y_ready;
         hold_d = y_data;
         hold_i = y_idx;
      end else begin
         hs_q   = 1'b0;
         hold_q = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      int prd_cnt;

      // Reset values
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_y_valid", 64'(y_valid), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_p_rd", 64'(p_rd), 64'd0);
      chk("rst_n_x", 64'(n_x), 64'd0);
      chk("rst_n_w", 64'(n_w), 64'd0);
      chk("rst_y_data", 64'(y_data), 64'd0);
      chk("rst_n_xmin", 64'(n_xmin), 64'hF80);
      chk("rst_n_xmax", 64'(n_xmax), 64'h07F);
      rst_n = 1'b1;

      // Layer A: streaming, y_ready high
      push_layer(32'h0101_0101);
      launch(32'h0101_0101, 33, 1'b1, 1'b0, 12'h0, 12'h0);
      repeat (40) @(posedge clk);
      chk("layerA_drained", 64'(sb.size()), 64'd0);

      // Layer B: ignored restart, ignored cfg write, backpressure at idx 2
      push_layer(32'h807F_02FE);
      launch(32'h807F_02FE, 38, 1'b1, 1'b0, 12'h0, 12'h0);
      @(posedge clk); #1;
      start = 1'b1; x_in = 32'hFFFF_FFFF; cfg_we = 1'b1; cfg_xmin = 12'hFCE; cfg_xmax = 12'h032;
      @(posedge clk); #1;
      start = 1'b0; cfg_we = 1'b0;
      chk("busy_cfg_xmin", 64'(n_xmin), 64'hF80);
      chk("busy_cfg_xmax", 64'(n_xmax), 64'h07F);
      chk("busy_start_n_x", 64'(n_x), 64'h807F_02FE);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (p_rd && p_addr == 3'd2) found = 1'b1;
      end
      chk("wait_fetch2", 64'(found), 64'd1);
      #1 y_ready = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (y_valid) found = 1'b1;
      end
      chk("wait_out2", 64'(found), 64'd1);
      repeat (5) @(posedge clk);
      #1 y_ready = 1'b1;
      repeat (30) @(posedge clk);
      chk("layerB_drained", 64'(sb.size()), 64'd0);

      // cfg write in IDLE takes effect next cycle
      #1 cfg_we = 1'b1; cfg_xmin = 12'hFCE; cfg_xmax = 12'h032;
      @(posedge clk); #1 cfg_we = 1'b0;
      chk("idle_cfg_xmin", 64'(n_xmin), 64'hFCE);
      chk("idle_cfg_xmax", 64'(n_xmax), 64'h032);

      // Start with cfg write, then abort in LOAD at idx 4
      push_layer(32'h1122_3344);
      launch(32'h1122_3344, 0, 1'b0, 1'b1, 12'hF9C, 12'h064);
      chk("start_cfg_xmin", 64'(n_xmin), 64'hF9C);
      chk("start_cfg_xmax", 64'(n_xmax), 64'h064);
      chk("start_cfg_n_x", 64'(n_x), 64'h1122_3344);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (p_rd && p_addr == 3'd4) found = 1'b1;
      end
      chk("wait_fetch4", 64'(found), 64'd1);
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_y_valid", 64'(y_valid), 64'd0);
      chk("abort_remaining", 64'(sb.size()), 64'd4);
      sb.delete();
      prd_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (p_rd) prd_cnt++;
      end
      chk("abort_no_prd", 64'(prd_cnt), 64'd0);

      // Restart after abort begins at idx 0
      push_layer(32'hA5A5_5A5A);
      launch(32'hA5A5_5A5A, 33, 1'b1, 1'b0, 12'h0, 12'h0);
      repeat (40) @(posedge clk);
      chk("restart_drained", 64'(sb.size()), 64'd0);

      // Reset pulse while in OUT
      #1 y_ready = 1'b0;
      push_layer(32'h0F0F_0F0F);
      launch(32'h0F0F_0F0F, 0, 1'b0, 1'b0, 12'h0, 12'h0);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (y_valid) found = 1'b1;
      end
      chk("wait_out0", 64'(found), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_y_valid", 64'(y_valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_xmin", 64'(n_xmin), 64'hF80);
      chk("mid_rst_xmax", 64'(n_xmax), 64'h07F);
      chk("mid_rst_n_x", 64'(n_x), 64'd0);
      sb.delete();
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1; y_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1 chk("post_rst_idle", 64'(busy), 64'd0);

      // Final full layer after reset
      push_layer(32'h0101_0101);
      launch(32'h0101_0101, 33, 1'b1, 1'b0, 12'h0, 12'h0);
      repeat (40) @(posedge clk);
      chk("final_drained", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
